// File: rtl/maple_bus_sequencer.sv
// Maple Bus transaction sequencer: TX enable, bus turnaround, RX wait/timeout.
// Optional MAPLE_SEQ_TX_WATCHDOG_EN aborts if the transmitter never starts.
module maple_bus_sequencer #(
  parameter int CNT_WIDTH         = 11,
  parameter int TO_WIDTH          = 20,
  parameter int TURNAROUND_CYCLES = 16,
  parameter int TX_WD_CYCLES      = 4096
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 expect_reply,
  input  logic [TO_WIDTH-1:0]  timeout_cycles,
  input  logic [CNT_WIDTH-1:0] tx_data_count,
  input  logic                 transmitting,
  input  logic                 receiving,
  input  logic                 rx_tlast_hs,
  output logic                 tx_enable,
  output logic                 bus_oe,
  output logic                 rx_enable,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           status
);

  if (TURNAROUND_CYCLES < 1) begin : g_bad_turn
    $error("TURNAROUND_CYCLES must be >= 1");
  end
  if (TX_WD_CYCLES < 1) begin : g_bad_wd
    $error("TX_WD_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_WAIT,
    S_TX_ACTIVE,
    S_TURN,
    S_RX_WAIT,
    S_RX_ACTIVE,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_NOREP = 2'd1;
  localparam logic [1:0] ST_EMPTY = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  localparam int TURN_W = $clog2(TURNAROUND_CYCLES + 1);
  localparam logic [TURN_W-1:0] TURN_LAST =
    TURN_W'(TURNAROUND_CYCLES - 1);

  state_t              state_q, state_d;
  logic                exp_q, exp_d;
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic [TO_WIDTH-1:0] tocnt_q, tocnt_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [1:0]          status_q, status_d;
  logic                tx_en_q, tx_en_d;
  logic                oe_q, oe_d;
  logic                rx_en_q, rx_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                to_hit;

`ifdef MAPLE_SEQ_TX_WATCHDOG_EN
  localparam int WD_W = $clog2(TX_WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_WD_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Count equals cycles spent in RX_WAIT so far; fire on the last one.
  assign to_hit = (to_q != '0) && (tocnt_q >= to_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    to_d     = to_q;
    tocnt_d  = tocnt_q;
    turn_d   = turn_q;
    status_d = status_q;
`ifdef MAPLE_SEQ_TX_WATCHDOG_EN
    wd_d     = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d    = expect_reply;
          to_d     = timeout_cycles;
          status_d = ST_OK;
`ifdef MAPLE_SEQ_TX_WATCHDOG_EN
          wd_d     = '0;
`endif
          if (tx_data_count == '0) begin
            state_d  = S_DONE;
            status_d = ST_EMPTY;
          end else begin
            state_d = S_TX_WAIT;
          end
        end
      end
      S_TX_WAIT: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (transmitting) begin
          state_d = S_TX_ACTIVE;
`ifdef MAPLE_SEQ_TX_WATCHDOG_EN
        end else if (wd_q >= WD_LAST) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      S_TX_ACTIVE: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (!transmitting) begin
          state_d = S_TURN;
          turn_d  = '0;
        end
      end
      S_TURN: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (turn_q >= TURN_LAST) begin
          if (exp_q) begin
            state_d = S_RX_WAIT;
            tocnt_d = '0;
          end else begin
            state_d  = S_DONE;
            status_d = ST_OK;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      S_RX_WAIT: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (receiving) begin
          state_d = S_RX_ACTIVE;
        end else if (to_hit) begin
          state_d  = S_DONE;
          status_d = ST_NOREP;
        end else if (tocnt_q != '1) begin
          tocnt_d = tocnt_q + 1'b1;
        end
      end
      S_RX_ACTIVE: begin
        if (rx_tlast_hs) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (abort || !receiving) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    tx_en_d = (state_d == S_TX_WAIT) || (state_d == S_TX_ACTIVE);
    oe_d    = tx_en_d;
    rx_en_d = (state_d == S_RX_WAIT) || (state_d == S_RX_ACTIVE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      exp_q    <= 1'b0;
      to_q     <= '0;
      tocnt_q  <= '0;
      turn_q   <= '0;
      status_q <= ST_OK;
      tx_en_q  <= 1'b0;
      oe_q     <= 1'b0;
      rx_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MAPLE_SEQ_TX_WATCHDOG_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      to_q     <= to_d;
      tocnt_q  <= tocnt_d;
      turn_q   <= turn_d;
      status_q <= status_d;
      tx_en_q  <= tx_en_d;
      oe_q     <= oe_d;
      rx_en_q  <= rx_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MAPLE_SEQ_TX_WATCHDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign tx_enable = tx_en_q;
  assign bus_oe    = oe_q;
  assign rx_enable = rx_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign status    = status_q;

endmodule

// File: tb/tb_maple_bus_sequencer.sv
// Directed bench for maple_bus_sequencer; expected timing worked out by hand.
// Define MAPLE_SEQ_TX_WATCHDOG_EN to exercise the TX watchdog (limit 64).
module tb_maple_bus_sequencer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        expect_reply = 1'b0;
  logic [19:0] timeout_cycles = '0;
  logic [10:0] tx_data_count = '0;
  logic        transmitting = 1'b0;
  logic        receiving = 1'b0;
  logic        rx_tlast_hs = 1'b0;
  logic        tx_enable, bus_oe, rx_enable, busy, done;
  logic [1:0]  status;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  maple_bus_sequencer #(
    .CNT_WIDTH(11),
    .TO_WIDTH(20),
    .TURNAROUND_CYCLES(16),
    .TX_WD_CYCLES(64)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .start(start),
    .abort(abort),
    .expect_reply(expect_reply),
    .timeout_cycles(timeout_cycles),
    .tx_data_count(tx_data_count),
    .transmitting(transmitting),
    .receiving(receiving),
    .rx_tlast_hs(rx_tlast_hs),
    .tx_enable(tx_enable),
    .bus_oe(bus_oe),
    .rx_enable(rx_enable),
    .busy(busy),
    .done(done),
    .status(status)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: sim did not finish, got t=%0t want <2ms",
             $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    cyc++;
    #1;
  endtask

  // Launch a 3-cycle transmit; returns at the last TURN cycle.
  task automatic do_tx(input logic exp, input logic [19:0] to);
    tx_data_count = 11'd5;
    expect_reply = exp;
    timeout_cycles = to;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    transmitting = 1'b1;
    repeat (3) tick();
    transmitting = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({tx_enable, bus_oe, rx_enable, busy, done, status} !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold: got %b want 0000000",
               {tx_enable, bus_oe, rx_enable, busy, done, status});
    end
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    cyc = 0;
    tick();
    checks++;
    if ({tx_enable, bus_oe, rx_enable, busy, done, status} !== 7'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b want 0000000",
               {tx_enable, bus_oe, rx_enable, busy, done, status});
    end
  endtask

  task automatic test_basic_tx();
    tx_data_count = 11'd5;
    expect_reply = 1'b0;
    timeout_cycles = '0;
    while (cyc < 10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 11; e <= 41; e++) begin
      if (e > 11) tick();
      checks++;
      if ({tx_enable, bus_oe, rx_enable, busy, done} !== 5'b11010) begin
        errors++;
        $display("FAIL tx_phase edge %0d: got %b want 11010", cyc,
                 {tx_enable, bus_oe, rx_enable, busy, done});
      end
      if (e == 13) transmitting = 1'b1;
      if (e == 41) transmitting = 1'b0;
    end
    for (int e = 42; e <= 57; e++) begin
      tick();
      checks++;
      if ({tx_enable, bus_oe, rx_enable, busy, done} !== 5'b00010) begin
        errors++;
        $display("FAIL turn edge %0d: got %b want 00010", cyc,
                 {tx_enable, bus_oe, rx_enable, busy, done});
      end
    end
    tick();
    checks++;
    if ({done, busy, status} !== 4'b1100 || cyc != 58) begin
      errors++;
      $display("FAIL basic_done edge %0d: got %b want 1100 at 58", cyc,
               {done, busy, status});
    end
    tick();
    checks++;
    if ({done, busy, status} !== 4'b0000) begin
      errors++;
      $display("FAIL basic_idle: got %b want 0000", {done, busy, status});
    end
  endtask

  task automatic test_no_reply();
    do_tx(1'b1, 20'd100);
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({tx_enable, bus_oe, rx_enable, done} !== 4'b0010) begin
        errors++;
        $display("FAIL rx_wait cycle %0d: got %b want 0010", i,
                 {tx_enable, bus_oe, rx_enable, done});
      end
    end
    tick();
    checks++;
    if ({tx_enable, bus_oe, rx_enable, done, status} !== 6'b000101) begin
      errors++;
      $display("FAIL no_reply_done: got %b want 000101",
               {tx_enable, bus_oe, rx_enable, done, status});
    end
    tick();
  endtask

  task automatic test_reply();
    do_tx(1'b1, 20'd100);
    repeat (20) tick();
    receiving = 1'b1;
    tick();
    checks++;
    if ({rx_enable, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL rx_active: got %b want 110", {rx_enable, busy, done});
    end
    repeat (49) tick();
    rx_tlast_hs = 1'b1;
    tick();
    rx_tlast_hs = 1'b0;
    receiving = 1'b0;
    checks++;
    if ({done, rx_enable, status} !== 4'b1000) begin
      errors++;
      $display("FAIL reply_done: got %b want 1000",
               {done, rx_enable, status});
    end
    tick();
    do_tx(1'b1, 20'd100);
    repeat (20) tick();
    receiving = 1'b1;
    repeat (6) tick();
    rx_tlast_hs = 1'b1;
    abort = 1'b1;
    tick();
    rx_tlast_hs = 1'b0;
    abort = 1'b0;
    receiving = 1'b0;
    checks++;
    if ({done, status} !== 3'b100) begin
      errors++;
      $display("FAIL tlast_vs_abort: got %b want 100", {done, status});
    end
    tick();
  endtask

  task automatic test_rx_boundary();
    do_tx(1'b1, 20'd5);
    repeat (5) tick();
    receiving = 1'b1;
    tick();
    checks++;
    if ({rx_enable, done} !== 2'b10) begin
      errors++;
      $display("FAIL recv_vs_timeout: got %b want 10", {rx_enable, done});
    end
    receiving = 1'b0;
    tick();
    checks++;
    if ({done, rx_enable, status} !== 4'b1011) begin
      errors++;
      $display("FAIL recv_drop: got %b want 1011",
               {done, rx_enable, status});
    end
    tick();
  endtask

  task automatic test_empty();
    tx_data_count = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({done, busy, tx_enable, bus_oe, status} !== 6'b110010) begin
      errors++;
      $display("FAIL empty_done: got %b want 110010",
               {done, busy, tx_enable, bus_oe, status});
    end
    tick();
    checks++;
    if ({done, busy, tx_enable, status} !== 5'b00010) begin
      errors++;
      $display("FAIL empty_idle: got %b want 00010",
               {done, busy, tx_enable, status});
    end
    tx_data_count = 11'd5;
  endtask

  task automatic test_abort();
    int extra_done;
    expect_reply = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    transmitting = 1'b1;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    transmitting = 1'b0;
    checks++;
    if ({tx_enable, bus_oe, done, status} !== 5'b00111) begin
      errors++;
      $display("FAIL abort_tx: got %b want 00111",
               {tx_enable, bus_oe, done, status});
    end
    extra_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL busy_start_ignored: got %0d busy/done cycles want 0",
               extra_done);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({tx_enable, bus_oe, busy, done} !== 4'b1110) begin
      errors++;
      $display("FAIL start_with_abort: got %b want 1110",
               {tx_enable, bus_oe, busy, done});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({tx_enable, done, status} !== 4'b0111) begin
      errors++;
      $display("FAIL abort_tx_wait: got %b want 0111",
               {tx_enable, done, status});
    end
    tick();
  endtask

  task automatic test_reset_rx();
    do_tx(1'b1, 20'd0);
    repeat (200) tick();
    checks++;
    if ({rx_enable, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL no_timeout: got %b want 110", {rx_enable, busy, done});
    end
    #2 areset = 1'b1;
    #1;
    checks++;
    if ({tx_enable, bus_oe, rx_enable, busy, done, status} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0000000",
               {tx_enable, bus_oe, rx_enable, busy, done, status});
    end
    @(negedge aclk);
    areset = 1'b0;
    tick();
    checks++;
    if ({rx_enable, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_to_idle: got %b want 000",
               {rx_enable, busy, done});
    end
  endtask

  task automatic test_watchdog();
    tx_data_count = 11'd5;
    expect_reply = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef MAPLE_SEQ_TX_WATCHDOG_EN
    repeat (63) tick();
    checks++;
    if ({tx_enable, done} !== 2'b10) begin
      errors++;
      $display("FAIL wd_before: got %b want 10", {tx_enable, done});
    end
    tick();
    checks++;
    if ({tx_enable, done, status} !== 4'b0111) begin
      errors++;
      $display("FAIL wd_fire: got %b want 0111",
               {tx_enable, done, status});
    end
`else
    repeat (200) tick();
    checks++;
    if ({tx_enable, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL tx_wait_hold: got %b want 110",
               {tx_enable, busy, done});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({tx_enable, done, status} !== 4'b0111) begin
      errors++;
      $display("FAIL tx_wait_abort: got %b want 0111",
               {tx_enable, done, status});
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_tx();
    test_no_reply();
    test_reply();
    test_rx_boundary();
    test_empty();
    test_abort();
    test_reset_rx();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
